tdm_demux1_4: RTL and testbench

//   Receive end of the 4:1 lane-select path: rebuilds a parallel LANES-wide word

---
 rtl/tdm_pkg.sv | 16 +
 rtl/tdm_slot_ctr.sv | 28 ++
 rtl/tdm_demux1_4.sv | 115 +++++++++++
 tb/tb_tdm_demux1_4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM lane-select types and defaults, used by both the mux and demux sides.
package tdm_pkg;

    localparam int DEF_LANES     = 4;
    localparam int DEF_WIDTH     = 1;
    localparam int DEF_ERR_LIMIT = 2;
    localparam int SLOT_W        = $clog2(DEF_LANES);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear beats load-to-1, which beats increment-with-wrap at LANES-1.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int SW    = $clog2(LANES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= (slot == SW'(LANES - 1)) ? '0 : slot + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux1_4.sv
// TDM receive demux: rebuilds LANES-wide frames from one slot per valid beat; dout/dout_valid one cycle after the last slot.
// No backpressure: every valid beat is consumed. TDM_DEMUX_FRAME_CNT_EN adds a 16-bit frame counter output.
module tdm_demux1_4
    import tdm_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   locked,
    output logic                   sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int SW  = $clog2(LANES);
    localparam int EW  = $clog2(ERR_LIMIT + 1);
    localparam int SHW = (LANES - 1) * WIDTH;

    state_t        state;
    logic [SW-1:0] slot;
    logic [SHW-1:0] shadow;
    logic [EW-1:0] err_cnt;
    logic          at_zero, is_last, bad_sync, hit_limit, frame_done;
    logic          slot_clr, slot_load1, slot_inc;

    // A sync beat is expected exactly when the counter sits on slot 0.
    assign at_zero    = (slot == '0);
    assign is_last    = (slot == SW'(LANES - 1));
    assign bad_sync   = (state == LOCKED) && (frame_sync != at_zero);
    assign hit_limit  = (int'(err_cnt) + 1 >= ERR_LIMIT);
    assign frame_done = din_valid && (state == LOCKED) && !bad_sync && is_last;

    always_comb begin
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;
        if (din_valid) begin
            if (state == HUNT)             slot_load1 = frame_sync;
            else if (bad_sync && hit_limit) slot_clr  = 1'b1;
            else if (bad_sync || at_zero)   slot_load1 = 1'b1;
            else                            slot_inc   = 1'b1;
        end
    end

    tdm_slot_ctr #(.LANES(LANES), .SW(SW)) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (slot_clr),
        .load1 (slot_load1),
        .inc   (slot_inc),
        .slot  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            shadow     <= '0;
            err_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (frame_sync) begin
                        shadow[0 +: WIDTH] <= din;
                        err_cnt            <= '0;
                        state              <= LOCKED;
                        locked             <= 1'b1;
                    end
                end else if (bad_sync) begin
                    sync_err <= 1'b1;
                    if (hit_limit) begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        err_cnt <= '0;
                    end else begin
                        // Flywheel: the offending beat restarts the frame as slot 0.
                        shadow[0 +: WIDTH] <= din;
                        err_cnt            <= err_cnt + 1'b1;
                    end
                end else if (at_zero) begin
                    shadow[0 +: WIDTH] <= din;
                    err_cnt            <= '0;
                end else if (frame_done) begin
                    dout       <= {din, shadow};
                    dout_valid <= 1'b1;
                end else begin
                    shadow[int'(slot) * WIDTH +: WIDTH] <= din;
                end
            end
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Bench for tdm_demux1_4: directed frame/sync/reset scenarios plus a random stream, scored against a queue-based model.
module tb_tdm_demux1_4;
    import tdm_pkg::*;

    localparam int LANES     = 4;
    localparam int WIDTH     = 1;
    localparam int ERR_LIMIT = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [WIDTH-1:0]       din = '0;
    logic                   din_valid = 1'b0;
    logic                   frame_sync = 1'b0;
    logic [LANES*WIDTH-1:0] dout;
    logic                   dout_valid, locked, sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0]            frame_cnt;
`endif

    tdm_demux1_4 #(.LANES(LANES), .WIDTH(WIDTH), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int vld_seen = 0;

    // Reference model: collected slots of the current frame plus lock/error bookkeeping.
    bit                     m_hunt;
    int                     m_errs;
    int                     m_frames;
    logic [WIDTH-1:0]       m_q[$];
    logic [LANES*WIDTH-1:0] e_dout;
    bit                     e_vld, e_lock, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_hunt   = 1'b1;
        m_errs   = 0;
        m_frames = 0;
        m_q.delete();
        e_dout   = '0;
        e_vld    = 1'b0;
        e_lock   = 1'b0;
        e_err    = 1'b0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [WIDTH-1:0] d);
        e_vld = 1'b0;
        e_err = 1'b0;
        if (!v) return;
        if (m_hunt) begin
            if (s) begin
                m_q.delete();
                m_q.push_back(d);
                m_errs = 0;
                m_hunt = 1'b0;
                e_lock = 1'b1;
            end
            return;
        end
        if (s != (m_q.size() == 0)) begin
            e_err = 1'b1;
            m_errs++;
            m_q.delete();
            if (m_errs >= ERR_LIMIT) begin
                m_hunt = 1'b1;
                e_lock = 1'b0;
                m_errs = 0;
            end else begin
                m_q.push_back(d);
            end
            return;
        end
        if (s) m_errs = 0;
        m_q.push_back(d);
        if (m_q.size() == LANES) begin
            for (int k = 0; k < LANES; k++) e_dout[k*WIDTH +: WIDTH] = m_q[k];
            e_vld = 1'b1;
            m_frames++;
            m_q.delete();
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_dout"},     32'(dout),       32'(e_dout));
        chk({tag, "_vld"},      32'(dout_valid), 32'(e_vld));
        chk({tag, "_locked"},   32'(locked),     32'(e_lock));
        chk({tag, "_sync_err"}, 32'(sync_err),   32'(e_err));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, score at the next falling edge.
    task automatic step(input string tag, input bit v, input bit s, input logic [WIDTH-1:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        model_beat(v, s, d);
        @(negedge clk);
        if (dout_valid) vld_seen++;
        check_outs(tag);
    endtask

    task automatic send_frame(input string tag, input logic [3:0] bits, input int max_gap, input bit sync_first);
        for (int k = 0; k < LANES; k++) begin
            repeat ($urandom_range(0, max_gap)) step(tag, 1'b0, 1'($urandom), WIDTH'($urandom));
            step(tag, 1'b1, sync_first && (k == 0), bits[k]);
        end
    endtask

    int v0;
    int tx_pos;
    bit rv, rs;

    initial begin
        model_reset();
        din_valid  = 1'b1;
        frame_sync = 1'b1;
        din        = '1;
        repeat (3) begin
            @(negedge clk);
            check_outs("reset");
        end
        rst_n = 1'b1;

        send_frame("t2", 4'b1101, 0, 1'b1);
        chk("t2_dout_value", 32'(dout), 32'hD);

        v0 = vld_seen;
        send_frame("t3", 4'b1101, 5, 1'b1);
        chk("t3_pulses", vld_seen - v0, 1);
        chk("t3_dout_value", 32'(dout), 32'hD);

        step("t4", 1'b1, 1'b1, 1'b0);
        step("t4", 1'b1, 1'b0, 1'b1);
        v0 = vld_seen;
        send_frame("t4", 4'b0110, 0, 1'b1);
        chk("t4_pulses", vld_seen - v0, 1);
        chk("t4_dout_value", 32'(dout), 32'h6);
        send_frame("t4b", 4'b1010, 2, 1'b1);

        step("t5", 1'b1, 1'b1, 1'b1);
        step("t5", 1'b1, 1'b0, 1'b0);
        step("t5", 1'b1, 1'b1, 1'b0);
        step("t5", 1'b1, 1'b0, 1'b1);
        step("t5", 1'b1, 1'b1, 1'b1);
        chk("t5_unlocked", 32'(locked), 32'h0);
        v0 = vld_seen;
        send_frame("t5h", 4'b1111, 1, 1'b0);
        chk("t5_hunt_pulses", vld_seen - v0, 0);
        send_frame("t5r", 4'b1001, 1, 1'b1);
        chk("t5_dout_value", 32'(dout), 32'h9);

        step("t6", 1'b1, 1'b1, 1'b1);
        step("t6", 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outs("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vld_seen;
        send_frame("t6", 4'b1011, 0, 1'b0);
        chk("t6_pulses", vld_seen - v0, 0);

        // Random stream: transmitter keeps its own slot position; occasional sync flips inject errors.
        tx_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rs = (tx_pos == 0) ^ ($urandom_range(0, 19) == 0);
            if (!rv) rs = 1'($urandom);
            step("rand", rv, rs, WIDTH'($urandom));
            if (rv) tx_pos = (tx_pos + 1) % LANES;
        end

`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
